tl_mem_burst_slave: RTL and testbench
=====================================

TL_MEM_BURST_SLAVE -- requirements
Module: tl_mem_burst_slave

Interface
REQ-001 SHALL have parameter DW, 128, data width in bits; power of two, >= 32.
REQ-002 SHALL have parameter AW, 32, address width.
REQ-003 SHALL have parameter DEPTH, 4096, RAM words of DW bits; power of two.
REQ-004 SHALL have parameter SRCW, 3, source-ID width.
REQ-005 SHALL have parameter SZW, 8, size field width.
REQ-006 SHALL have ports: clk input 1 clock; rst input 1 reset, asynchronous, active-high.
REQ-007 SHALL have A-channel inputs: a_opcode 3; a_param 3; a_size SZW (log2 bytes); a_source SRCW; a_address AW; a_mask DW/8; a_data DW; a_corrupt 1; a_valid 1. SHALL have output a_ready 1.
REQ-008 SHALL have D-channel outputs: d_opcode 3; d_param 2; d_size SZW; d_source SRCW; d_sink 3; d_denied 1; d_data DW; d_corrupt 1; d_valid 1. SHALL have input d_ready 1.

Function
REQ-009 SHALL support Get(4), PutFullData(0) and PutPartialData(1), using a 4-state FSM: IDLE, WBURST, WRESP, RBURST.
REQ-010 A beat SHALL fire when valid & ready. BEATS = max(1, 2^a_size / (DW/8)); all BEATS share the first beat's size and source.
REQ-011 Word index SHALL be address[log2(DW/8) +: log2(DEPTH)]. Each beat SHALL add +1 to the index, wrapping modulo DEPTH.
REQ-012 a_ready SHALL be 1 in IDLE and WBURST, and 0 in WRESP and RBURST.
REQ-013 Put fire in IDLE: beat 0 SHALL be written with per-byte a_mask. If BEATS==1 the FSM SHALL go to WRESP, else to WBURST.
REQ-014 WBURST: each fired beat SHALL be written to the next index; on the last beat the FSM SHALL go to WRESP.
REQ-015 WRESP: d_valid=1, d_opcode=AccessAck(0). On d fire the FSM SHALL go to IDLE.
REQ-016 Get fire in IDLE: the FSM SHALL go to RBURST. d_valid SHALL rise exactly 1 cycle after the fire, with d_opcode=AccessAckData(1).
REQ-017 RBURST: each d fire SHALL advance to the next beat with no bubble. After the last beat fires, the FSM SHALL go to IDLE.
REQ-018 While d_valid & ~d_ready, all d_* outputs SHALL hold stable.
REQ-019 d_source and d_size SHALL echo the latched request. d_param, d_sink and d_corrupt SHALL be 0, except as stated in REQ-024.
REQ-020 Other opcodes (2,3,5,6,7): the block SHALL accept one beat, leave RAM unmodified, go to WRESP, and respond AccessAck with d_denied=1.
REQ-021 a_corrupt=1 on a Put beat SHALL suppress that beat's write; the response SHALL have d_corrupt=0 and d_denied=1.
REQ-022 A-channel traffic while a_ready=0 SHALL be ignored. The block SHALL track one outstanding transaction only.

Reset
REQ-023 On rst: FSM SHALL enter IDLE; d_valid=0, a_ready=1, latched size/source/index=0, d_data=0. RAM contents SHALL NOT be cleared. A reset mid-burst SHALL abandon the transaction with no response.

Configuration
REQ-024 Macro TL_MEM_OOR_DENY_EN: when defined, a request with address >= DEPTH*DW/8 SHALL perform no writes. Reads of such a request SHALL return d_data=0 and d_corrupt=1. All responses to such a request SHALL have d_denied=1.
REQ-025 When TL_MEM_OOR_DENY_EN is undefined, the address SHALL alias modulo DEPTH*DW/8 and d_denied SHALL be 0 for supported opcodes.

Structure
REQ-026 Package tl_pkg SHALL hold the A/D opcode constants (Get, PutFullData, PutPartialData, AccessAck, AccessAckData) and the FSM state typedef.
REQ-027 Sub-module tl_mem_bank SHALL implement the synchronous single-port byte-masked RAM, DW x DEPTH, with 1-cycle read latency. The top SHALL hold the FSM, counters and D-register.

Verification
REQ-028 Reset, then a Get of 16B at 0x0 -> one AccessAckData beat, d_data=0 or preload, d_source echoed.
REQ-029 PutFull size=6 at 0x100, data 0xA0..0xA3 over 4 beats, then a Get of the same -> single AccessAck, then 4 beats 0xA0..0xA3 in order with no gaps while d_ready=1.
REQ-030 PutPartial mask=0x000F data=0xFFFF..., then a Get -> only bytes 0-3 change.
REQ-031 Get of 4 beats with d_ready toggling 1/0 each cycle -> d_data stable on stall cycles; 4 beats, a_ready=0 throughout.
REQ-032 Burst at index DEPTH-2 of 4 beats -> beats 3-4 land at indexes 0-1.
REQ-033 Opcode 5 -> AccessAck with d_denied=1, RAM unchanged. With TL_MEM_OOR_DENY_EN, a Get at 0x10000 -> d_denied=1, d_corrupt=1, d_data=0.

Source files
------------

// File: rtl/tl_pkg.sv
// TileLink-UL memory slave shared definitions: opcodes, FSM state encoding, beat-count helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tl_pkg;

    // A-channel request opcodes
    localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_A_GET         = 3'd4;

    // D-channel response opcodes
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    // Slave FSM state encoding
    typedef logic [1:0] tl_state_t;
    localparam tl_state_t ST_IDLE   = 2'd0;
    localparam tl_state_t ST_WBURST = 2'd1;
    localparam tl_state_t ST_WRESP  = 2'd2;
    localparam tl_state_t ST_RBURST = 2'd3;

    // Remaining-beat counter; bursts longer than 2^32 beats saturate
    typedef logic [31:0] tl_beat_cnt_t;

    // Beats minus one for a transfer of 2^size bytes on a bus of 2^offw bytes
    function automatic tl_beat_cnt_t tl_beats_m1(input int unsigned size, input int unsigned offw);
        if (size <= offw) begin
            return '0;
        end
        if ((size - offw) >= 32) begin
            return '1;
        end
        return (32'd1 << (size - offw)) - 32'd1;
    endfunction

endpackage

// File: rtl/tl_mem_bank.sv
// Single-port DW x DEPTH RAM with per-byte write mask and registered read port.
// Latency: read data valid one cycle after en & ~we; write lands on the same edge.
// Backpressure: none; read register holds its value until the next read.
module tl_mem_bank
    import tl_pkg::*;
#(
    parameter int DW    = 128,
    parameter int DEPTH = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DW/8-1:0]            wmask,
    input  logic [DW-1:0]              wdata,
    output logic [DW-1:0]              rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Byte-masked write; array contents are never reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wmask[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register only updates on a read, so it doubles as the stable response data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/tl_mem_burst_slave.sv
// TileLink-UL burst memory slave: Get / PutFull / PutPartial into a byte-masked RAM bank.
// Latency: read data one cycle after the Get fires, then one beat per cycle; write ack right after last beat.
// Backpressure: a_ready drops while a response is pending; D outputs hold while d_ready is low.
// Optional feature: define TL_MEM_OOR_DENY_EN to deny requests beyond the RAM's byte range.
module tl_mem_burst_slave
    import tl_pkg::*;
#(
    parameter int DW    = 128,
    parameter int AW    = 32,
    parameter int DEPTH = 4096,
    parameter int SRCW  = 3,
    parameter int SZW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [SZW-1:0]    a_size,
    input  logic [SRCW-1:0]   a_source,
    input  logic [AW-1:0]     a_address,
    input  logic [DW/8-1:0]   a_mask,
    input  logic [DW-1:0]     a_data,
    input  logic              a_corrupt,
    input  logic              a_valid,
    output logic              a_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_param,
    output logic [SZW-1:0]    d_size,
    output logic [SRCW-1:0]   d_source,
    output logic [2:0]        d_sink,
    output logic              d_denied,
    output logic [DW-1:0]     d_data,
    output logic              d_corrupt,
    output logic              d_valid,
    input  logic              d_ready
);

    localparam int OFFW = $clog2(DW/8);
    localparam int IDXW = $clog2(DEPTH);
    localparam int HIW  = OFFW + IDXW;

    tl_state_t       st;
    logic [IDXW-1:0] idx_q;
    tl_beat_cnt_t    cnt_q;
    logic [SZW-1:0]  size_q;
    logic [SRCW-1:0] src_q;
    logic            denied_q;
    logic            oor_q;

    logic            a_fire;
    logic            d_fire;
    logic [IDXW-1:0] a_idx;
    logic            is_get;
    logic            is_put;
    logic            req_oor;
    tl_beat_cnt_t    a_beats_m1;

    logic            ram_en;
    logic            ram_we;
    logic [IDXW-1:0] ram_addr;
    logic [DW-1:0]   ram_rdata;

    logic            unused_bits;
    assign unused_bits = ^{a_param, a_address};

    assign a_fire     = a_valid & a_ready;
    assign d_fire     = d_valid & d_ready;
    assign a_idx      = a_address[OFFW +: IDXW];
    assign is_get     = (a_opcode == TL_A_GET);
    assign is_put     = (a_opcode == TL_A_PUT_FULL) || (a_opcode == TL_A_PUT_PARTIAL);
    assign a_beats_m1 = tl_beats_m1(32'(a_size), OFFW);

`ifdef TL_MEM_OOR_DENY_EN
    // Any address bit above the RAM's byte range marks the request out of range
    if (AW > HIW) begin : g_oor
        assign req_oor = |a_address[AW-1:HIW];
    end else begin : g_no_oor
        assign req_oor = 1'b0;
    end
`else
    // Upper address bits are ignored, so the RAM aliases across the address space
    assign req_oor = 1'b0;
`endif

    // RAM port steering: first beat uses the request address, later beats the running index
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = idx_q;
        case (st)
            ST_IDLE: begin
                if (a_fire) begin
                    ram_addr = a_idx;
                    if (is_get) begin
                        ram_en = 1'b1;
                    end else if (is_put && !a_corrupt && !req_oor) begin
                        ram_en = 1'b1;
                        ram_we = 1'b1;
                    end
                end
            end
            ST_WBURST: begin
                if (a_fire && !a_corrupt && !oor_q) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                end
            end
            ST_RBURST: begin
                // Prefetch the next beat as the current one is accepted, so there is no bubble
                if (d_fire && (cnt_q != '0)) begin
                    ram_en = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    tl_mem_bank #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wmask (a_mask),
        .wdata (a_data),
        .rdata (ram_rdata)
    );

    // Transaction FSM with latched request fields and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            size_q   <= '0;
            src_q    <= '0;
            denied_q <= 1'b0;
            oor_q    <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (a_fire) begin
                        size_q <= a_size;
                        src_q  <= a_source;
                        idx_q  <= a_idx + 1'b1;
                        cnt_q  <= a_beats_m1;
                        oor_q  <= req_oor;
                        if (is_get) begin
                            denied_q <= req_oor;
                            st       <= ST_RBURST;
                        end else if (is_put) begin
                            denied_q <= req_oor | a_corrupt;
                            st       <= (a_beats_m1 == '0) ? ST_WRESP : ST_WBURST;
                        end else begin
                            // Unsupported opcode: single beat swallowed, denied ack
                            cnt_q    <= '0;
                            denied_q <= 1'b1;
                            st       <= ST_WRESP;
                        end
                    end
                end
                ST_WBURST: begin
                    if (a_fire) begin
                        idx_q    <= idx_q + 1'b1;
                        cnt_q    <= cnt_q - 1'b1;
                        denied_q <= denied_q | a_corrupt;
                        if (cnt_q == 32'd1) begin
                            st <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (d_fire) begin
                        st <= ST_IDLE;
                    end
                end
                ST_RBURST: begin
                    if (d_fire) begin
                        if (cnt_q == '0) begin
                            st <= ST_IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

    // D channel is decoded from state and latched fields, so it is stable until it fires
    assign a_ready   = (st == ST_IDLE) || (st == ST_WBURST);
    assign d_valid   = (st == ST_WRESP) || (st == ST_RBURST);
    assign d_opcode  = (st == ST_RBURST) ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
    assign d_param   = 2'd0;
    assign d_sink    = 3'd0;
    assign d_size    = size_q;
    assign d_source  = src_q;
    assign d_denied  = denied_q;
    assign d_corrupt = oor_q && (st == ST_RBURST);
    assign d_data    = oor_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_tl_mem_burst_slave.sv
// Directed bench for tl_mem_burst_slave: bursts, partial writes, wrap, stalls, denials, reset.
// Latency: n/a.
// Backpressure: exercises d_ready stalls on read bursts.
module tb_tl_mem_burst_slave;

    localparam int DW    = 128;
    localparam int AW    = 32;
    localparam int DEPTH = 4096;
    localparam int SRCW  = 3;
    localparam int SZW   = 8;
    localparam int MW    = DW/8;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      a_opcode;
    logic [2:0]      a_param;
    logic [SZW-1:0]  a_size;
    logic [SRCW-1:0] a_source;
    logic [AW-1:0]   a_address;
    logic [MW-1:0]   a_mask;
    logic [DW-1:0]   a_data;
    logic            a_corrupt;
    logic            a_valid;
    logic            a_ready;
    logic [2:0]      d_opcode;
    logic [1:0]      d_param;
    logic [SZW-1:0]  d_size;
    logic [SRCW-1:0] d_source;
    logic [2:0]      d_sink;
    logic            d_denied;
    logic [DW-1:0]   d_data;
    logic            d_corrupt;
    logic            d_valid;
    logic            d_ready;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] wdat_q [0:7];
    logic [DW-1:0] exp_q  [0:7];

    always #5 clk = ~clk;

    tl_mem_burst_slave #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .SRCW(SRCW), .SZW(SZW)
    ) dut (
        .clk(clk), .rst(rst),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
        .a_valid(a_valid), .a_ready(a_ready),
        .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
        .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
        .d_valid(d_valid), .d_ready(d_ready)
    );

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] bytes_of(input logic [7:0] b);
        return {MW{b}};
    endfunction

    // Drive nb beats of a write-type request, then take its single AccessAck
    task automatic do_put(input logic [2:0] opc, input logic [7:0] size, input logic [31:0] addr,
                          input logic [2:0] src, input int nb, input logic [MW-1:0] mask,
                          input int bad_beat, input logic exp_den);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            a_opcode  = opc;
            a_size    = size;
            a_source  = src;
            a_address = addr;
            a_mask    = mask;
            a_data    = wdat_q[i];
            a_corrupt = (i == bad_beat);
            a_valid   = 1'b1;
            chk("wr_ardy", a_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        a_valid   = 1'b0;
        a_corrupt = 1'b0;
        chk("wr_dvld", d_valid, 1);
        chk("wr_opc", d_opcode, 0);
        chk("wr_den", d_denied, exp_den);
        chk("wr_cor", d_corrupt, 0);
        chk("wr_src", d_source, src);
        chk("wr_size", d_size, size);
        chk("wr_ardy0", a_ready, 0);
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wr_done", d_valid, 0);
        chk("wr_idle", a_ready, 1);
    endtask

    // Issue a Get and collect nb beats, optionally stalling every other cycle
    task automatic do_get(input logic [7:0] size, input logic [31:0] addr, input logic [2:0] src,
                          input int nb, input bit toggle, input bit chk_dat,
                          input logic exp_den, input logic exp_cor);
        int got;
        @(negedge clk);
        a_opcode  = 3'd4;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = '1;
        a_data    = '0;
        a_corrupt = 1'b0;
        a_valid   = 1'b1;
        chk("rd_ardy1", a_ready, 1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 64 && got < nb; cyc++) begin
            if (cyc > 0) @(negedge clk);
            d_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            chk("rd_vld", d_valid, 1);
            chk("rd_opc", d_opcode, 1);
            chk("rd_ardy0", a_ready, 0);
            chk("rd_src", d_source, src);
            chk("rd_size", d_size, size);
            chk("rd_den", d_denied, exp_den);
            chk("rd_cor", d_corrupt, exp_cor);
            if (chk_dat) chk("rd_dat", d_data, exp_q[got]);
            if (d_valid && d_ready) got++;
            @(posedge clk);
        end
        chk("rd_beats", got, nb);
        @(negedge clk);
        chk("rd_done", d_valid, 0);
        chk("rd_idle", a_ready, 1);
        d_ready = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] w10;
        rst = 1'b1;
        a_opcode = '0; a_param = '0; a_size = '0; a_source = '0; a_address = '0;
        a_mask = '0; a_data = '0; a_corrupt = 1'b0; a_valid = 1'b0; d_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_ardy", a_ready, 1);
        chk("rst_dvld", d_valid, 0);
        chk("rst_ddat", d_data, 0);
        chk("rst_dsize", d_size, 0);
        chk("rst_dsrc", d_source, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single-beat Get at 0 straight after reset (contents not yet defined)
        do_get(8'd4, 32'h0, 3'd3, 1, 1'b0, 1'b0, 1'b0, 1'b0);

        // PutFull of 64 bytes at 0x100, then read back without stalls
        for (int i = 0; i < 4; i++) wdat_q[i] = bytes_of(8'(8'hA0 + i));
        do_put(3'd0, 8'd6, 32'h100, 3'd2, 4, '1, -1, 1'b0);
        for (int i = 0; i < 4; i++) exp_q[i] = bytes_of(8'(8'hA0 + i));
        do_get(8'd6, 32'h100, 3'd5, 4, 1'b0, 1'b1, 1'b0, 1'b0);

        // PutPartial touching bytes 0-3 only
        wdat_q[0] = '1;
        do_put(3'd1, 8'd4, 32'h100, 3'd1, 1, 16'h000F, -1, 1'b0);
        w10 = {{12{8'hA0}}, 32'hFFFF_FFFF};
        exp_q[0] = w10;
        do_get(8'd4, 32'h100, 3'd1, 1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Stalled read burst: data must hold through every d_ready=0 cycle
        exp_q[0] = w10;
        for (int i = 1; i < 4; i++) exp_q[i] = bytes_of(8'(8'hA0 + i));
        do_get(8'd6, 32'h100, 3'd6, 4, 1'b1, 1'b1, 1'b0, 1'b0);

        // Burst starting at index DEPTH-2 wraps onto indexes 0 and 1
        for (int i = 0; i < 4; i++) wdat_q[i] = bytes_of(8'(8'hB0 + i));
        do_put(3'd0, 8'd6, 32'hFFE0, 3'd4, 4, '1, -1, 1'b0);
        exp_q[0] = bytes_of(8'hB2);
        exp_q[1] = bytes_of(8'hB3);
        do_get(8'd5, 32'h0, 3'd0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) exp_q[i] = bytes_of(8'(8'hB0 + i));
        do_get(8'd6, 32'hFFE0, 3'd7, 4, 1'b1, 1'b1, 1'b0, 1'b0);

        // Unsupported opcode 5: denied ack, RAM untouched
        wdat_q[0] = bytes_of(8'h55);
        do_put(3'd5, 8'd4, 32'h100, 3'd2, 1, '1, -1, 1'b1);
        exp_q[0] = w10;
        do_get(8'd4, 32'h100, 3'd2, 1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Corrupt Put beat: write suppressed, ack denied
        wdat_q[0] = bytes_of(8'hCC);
        do_put(3'd0, 8'd4, 32'h120, 3'd3, 1, '1, 0, 1'b1);
        exp_q[0] = bytes_of(8'hA2);
        do_get(8'd4, 32'h120, 3'd3, 1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Address beyond the RAM byte range
`ifdef TL_MEM_OOR_DENY_EN
        exp_q[0] = '0;
        do_get(8'd4, 32'h10000, 3'd1, 1, 1'b0, 1'b1, 1'b1, 1'b1);
`else
        exp_q[0] = bytes_of(8'hB2);
        do_get(8'd4, 32'h10000, 3'd1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        // Reset in the middle of a write burst: no response, RAM keeps written beats
        wdat_q[0] = bytes_of(8'hC0);
        wdat_q[1] = bytes_of(8'hC1);
        do_put(3'd0, 8'd5, 32'h400, 3'd5, 2, '1, -1, 1'b0);
        @(negedge clk);
        a_opcode = 3'd0; a_size = 8'd5; a_source = 3'd6; a_address = 32'h400;
        a_mask = '1; a_data = bytes_of(8'hD0); a_corrupt = 1'b0; a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_dvld", d_valid, 0);
        chk("mrst_ardy", a_ready, 1);
        chk("mrst_dsize", d_size, 0);
        chk("mrst_dsrc", d_source, 0);
        chk("mrst_ddat", d_data, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q[0] = bytes_of(8'hD0);
        exp_q[1] = bytes_of(8'hC1);
        do_get(8'd5, 32'h400, 3'd2, 2, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
        $fatal(1);
    end

endmodule
